// File: rtl/lap_stash.sv
// lap_stash: circular store of the last DEPTH lap samples with a registered
// display pointer that jumps to each new write and steps newer/older through
// the valid entries only.
// Optional feature macro: LAP_STASH_NAV_WRAP_EN (wrap navigation at the
// newest/oldest entries instead of saturating).
module lap_stash #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 10,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_in_valid,
    input  logic             next_sample,
    input  logic             prev_sample,
    input  logic             clear,
    output logic [WIDTH-1:0] sample_out,
    output logic [AW-1:0]    sample_age,
    output logic [CW-1:0]    sample_count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_show_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sample_out;
    logic [AW-1:0]    r_age;

    logic             w_newer;
    logic             w_older;
    logic             w_at_newest;
    logic             w_at_oldest;
    logic             w_move;
    logic [AW-1:0]    w_show_nxt;
    logic [AW-1:0]    w_age_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? AW'(DEPTH - 1) : p - 1'b1;
    endfunction

`ifdef LAP_STASH_NAV_WRAP_EN
    localparam int unsigned TW = CW + 1;
    logic [TW-1:0] w_oldest_sum;
    logic [AW-1:0] w_oldest_ptr;

    // Physical slot of the oldest valid entry: (wr_ptr - count) mod DEPTH
    always_comb begin
        w_oldest_sum = TW'(r_wr_ptr) + TW'(DEPTH) - TW'(r_count);
        if (w_oldest_sum >= TW'(DEPTH)) begin
            w_oldest_sum = w_oldest_sum - TW'(DEPTH);
        end
        w_oldest_ptr = AW'(w_oldest_sum);
    end
`endif

    // Navigation decode: next display pointer and age when no write/clear
    always_comb begin
        w_newer     = next_sample & ~prev_sample & (r_count != '0);
        w_older     = prev_sample & ~next_sample & (r_count != '0);
        w_at_newest = (r_age == '0);
        w_at_oldest = (CW'(r_age) == r_count - 1'b1);
        w_show_nxt  = r_show_ptr;
        w_age_nxt   = r_age;
        w_move      = 1'b0;
        if (w_newer) begin
            if (!w_at_newest) begin
                w_show_nxt = ptr_inc(r_show_ptr);
                w_age_nxt  = r_age - 1'b1;
                w_move     = 1'b1;
            end else begin
`ifdef LAP_STASH_NAV_WRAP_EN
                w_show_nxt = w_oldest_ptr;
                w_age_nxt  = AW'(r_count - 1'b1);
                w_move     = 1'b1;
`endif
            end
        end else if (w_older) begin
            if (!w_at_oldest) begin
                w_show_nxt = ptr_dec(r_show_ptr);
                w_age_nxt  = r_age + 1'b1;
                w_move     = 1'b1;
            end else begin
`ifdef LAP_STASH_NAV_WRAP_EN
                w_show_nxt = ptr_dec(r_wr_ptr);
                w_age_nxt  = '0;
                w_move     = 1'b1;
`endif
            end
        end
    end

    // State update with priority reset > clear > write > navigation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_show_ptr   <= '0;
            r_count      <= '0;
            r_sample_out <= '0;
            r_age        <= '0;
        end else if (clear) begin
            r_wr_ptr     <= '0;
            r_show_ptr   <= '0;
            r_count      <= '0;
            r_sample_out <= '0;
            r_age        <= '0;
        end else if (sample_in_valid) begin
            r_mem[r_wr_ptr] <= sample_in;
            r_show_ptr      <= r_wr_ptr;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
            if (r_count != CW'(DEPTH)) begin
                r_count <= r_count + 1'b1;
            end
            r_sample_out    <= sample_in;
            r_age           <= '0;
        end else if (w_move) begin
            r_show_ptr   <= w_show_nxt;
            r_age        <= w_age_nxt;
            r_sample_out <= r_mem[w_show_nxt];
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_age   = r_age;
    assign sample_count = r_count;
    assign empty        = (r_count == '0);
    assign full         = (r_count == CW'(DEPTH));

endmodule

// File: tb/tb_lap_stash.sv
// Directed bench for lap_stash at WIDTH=8, DEPTH=4. Expectations for the
// boundary behaviour follow LAP_STASH_NAV_WRAP_EN when it is defined.
module tb_lap_stash;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_in_valid = 1'b0;
    logic             next_sample = 1'b0;
    logic             prev_sample = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] sample_out;
    logic [1:0]       sample_age;
    logic [2:0]       sample_count;
    logic             empty;
    logic             full;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    lap_stash #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .next_sample     (next_sample),
        .prev_sample     (prev_sample),
        .clear           (clear),
        .sample_out      (sample_out),
        .sample_age      (sample_age),
        .sample_count    (sample_count),
        .empty           (empty),
        .full            (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] e_out, input int e_age,
                             input int e_cnt);
        chk({tag, ".out"},   32'(sample_out),   32'(e_out));
        chk({tag, ".age"},   32'(sample_age),   32'(e_age));
        chk({tag, ".count"}, 32'(sample_count), 32'(e_cnt));
        chk({tag, ".empty"}, 32'(empty),        32'(e_cnt == 0));
        chk({tag, ".full"},  32'(full),         32'(e_cnt == DEPTH));
    endtask

    // One clock with the given strobes, then strobes dropped; sample at +1
    task automatic cyc(input logic v, input logic [7:0] d, input logic n, input logic p,
                       input logic c);
        sample_in_valid = v;
        sample_in       = d;
        next_sample     = n;
        prev_sample     = p;
        clear           = c;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
        sample_in       = '0;
        next_sample     = 1'b0;
        prev_sample     = 1'b0;
        clear           = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] vals [6];
        vals = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};

        // Reset and empty
        do_reset();
        chk_state("rst", 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("empty_next", 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("empty_prev", 8'h00, 0, 0);

        // Fill and overwrite; next on the A2 write is ignored
        for (int i = 0; i < 6; i++) begin
            cyc(1, vals[i], (i == 2), 0, 0);
            chk_state($sformatf("wr%0d", i), vals[i], 0, (i < 4) ? i + 1 : 4);
        end
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("ov_prev1", 8'hA4, 1, 4);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("ov_prev2", 8'hA3, 2, 4);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("ov_prev3", 8'hA2, 3, 4);
        cyc(0, 8'h00, 0, 1, 0);
`ifdef LAP_STASH_NAV_WRAP_EN
        chk_state("ov_prev4", 8'hA5, 0, 4);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("ov_wrapback", 8'hA2, 3, 4);
`else
        chk_state("ov_prev4", 8'hA2, 3, 4);
`endif

        // Simultaneous strobes from age 2
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("sim_age2", 8'hA3, 2, 4);
        cyc(0, 8'h00, 1, 1, 0);
        chk_state("sim_both", 8'hA3, 2, 4);
        cyc(1, 8'h77, 0, 0, 1);
        chk_state("sim_clr", 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("sim_clr_prev", 8'h00, 0, 0);

        // Partial fill navigation
        do_reset();
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        chk_state("pf_wr", 8'h22, 0, 2);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("pf_prev", 8'h11, 1, 2);
        cyc(0, 8'h00, 0, 1, 0);
`ifdef LAP_STASH_NAV_WRAP_EN
        chk_state("pf_prev2", 8'h22, 0, 2);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("pf_next", 8'h11, 1, 2);
`else
        chk_state("pf_prev2", 8'h11, 1, 2);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("pf_next", 8'h22, 0, 2);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("pf_next2", 8'h22, 0, 2);
`endif

        // Mid-navigation write at age 3
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 0, 1, 0);
        end
        chk_state("mn_age3", 8'h01, 3, 4);
        cyc(1, 8'h5A, 0, 0, 0);
        chk_state("mn_wr", 8'h5A, 0, 4);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("mn_p1", 8'h04, 1, 4);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("mn_p2", 8'h03, 2, 4);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("mn_p3", 8'h02, 3, 4);

        // Held strobe: two cycles of next move two steps
        next_sample = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        next_sample = 1'b0;
        chk_state("hold_next", 8'h04, 1, 4);

        // Clear then refill
        cyc(0, 8'h00, 0, 0, 1);
        chk_state("cr_clr", 8'h00, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        chk_state("cr_wr", 8'h33, 0, 1);
        cyc(0, 8'h00, 0, 1, 0);
        chk_state("cr_prev", 8'h33, 0, 1);
        cyc(0, 8'h00, 1, 0, 0);
        chk_state("cr_next", 8'h33, 0, 1);

        // Reset during navigation wins over the strobe
        cyc(1, 8'h44, 0, 0, 0);
        reset       = 1'b1;
        prev_sample = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        prev_sample = 1'b0;
        chk_state("rst_nav", 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
